spinner_quad_gen: RTL



---
 rtl/spinner_quad_gen_pkg.sv | 49 ++++
 rtl/spinner_quad_gen_step_timer.sv | 30 +++
 rtl/spinner_quad_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spinner_quad_gen_pkg.sv
// Shared types and helpers for the spinner quadrature generator:
// direction encoding, Gray dial table and phase stepping.
package spinner_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_t;

  localparam logic [1:0] PH_RESET   = 2'd0;
  localparam logic [1:0] DIAL_RESET = 2'b11;

  function automatic logic [1:0] phase_to_dial(input logic [1:0] ph);
    logic [1:0] d;
    case (ph)
      2'd0:    d = 2'b11;
      2'd1:    d = 2'b01;
      2'd2:    d = 2'b00;
      default: d = 2'b10;
    endcase
    return d;
  endfunction

  // Wraps silently modulo 4 in either direction.
  function automatic logic [1:0] phase_advance(input logic [1:0] ph, input dir_t dir);
    logic [1:0] n;
    case (dir)
      DIR_CW:  n = ph + 2'd1;
      DIR_CCW: n = ph - 2'd1;
      default: n = ph;
    endcase
    return n;
  endfunction

  // Both or neither request (after mirroring) means no motion.
  function automatic dir_t decode_dir(input logic cw, input logic ccw, input logic invert);
    logic eff_cw;
    logic eff_ccw;
    dir_t d;
    eff_cw  = invert ? ccw : cw;
    eff_ccw = invert ? cw : ccw;
    if (eff_cw && !eff_ccw)      d = DIR_CW;
    else if (eff_ccw && !eff_cw) d = DIR_CCW;
    else                         d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/spinner_quad_gen_step_timer.sv
// Reloadable down-counter; expire is high while the count sits at zero.
// hold has priority over load so a paused timer keeps its exact position.
module step_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (hold) begin
      r_cnt <= r_cnt;
    end else if (load) begin
      r_cnt <= period;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/spinner_quad_gen.sv
// Turns held up/down requests into a timed Gray-coded dial phase with
// acceleration; one instance per player.
module spinner_quad_gen
  import spinner_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int STEP_SLOW_HZ = 250,
  parameter int STEP_FAST_HZ = 1000,
  parameter int ACCEL_STEPS  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cw,
  input  logic       ccw,
  input  logic       invert,
  input  logic       pause,
  output logic [1:0] dial,
  output logic       step,
  output logic       moving
);

  localparam int P_SLOW = CLK_HZ / STEP_SLOW_HZ;
  localparam int P_FAST = CLK_HZ / STEP_FAST_HZ;
  localparam int CNT_W  = $clog2(P_SLOW + 1);
  localparam int ACC_W  = $clog2(ACCEL_STEPS + 1);

  localparam logic [CNT_W-1:0] RELOAD_SLOW = CNT_W'(P_SLOW - 1);
  localparam logic [CNT_W-1:0] RELOAD_FAST = CNT_W'(P_FAST - 1);
  localparam logic [ACC_W-1:0] ACC_MAX     = ACC_W'(ACCEL_STEPS);
  localparam logic [ACC_W-1:0] ACC_ONE     = ACC_W'(1);

  if (P_FAST < 1 || P_FAST > P_SLOW) begin : g_bad_rates
    $error("spinner_quad_gen: fast period must be in 1..slow period");
  end

  dir_t             r_cur_dir;
  logic [1:0]       r_ph;
  logic [ACC_W-1:0] r_accel;
  logic [1:0]       r_dial;
  logic             r_step;
  logic             r_moving;

  dir_t             w_dir_req;
  dir_t             w_step_dir;
  logic             w_take_step;
  logic             w_expire;
  logic             w_timer_hold;
  logic             w_timer_load;
  logic [CNT_W-1:0] w_timer_period;
  logic [ACC_W-1:0] w_accel_inc;
  logic [ACC_W-1:0] w_accel_next;
  logic [1:0]       w_ph_next;

  always_comb begin
    w_dir_req      = decode_dir(cw, ccw, invert);
    w_step_dir     = DIR_NONE;
    w_take_step    = 1'b0;
    w_timer_hold   = enable & pause;
    w_timer_load   = 1'b0;
    w_timer_period = '0;
    w_accel_inc    = (r_accel >= ACC_MAX) ? ACC_MAX : r_accel + 1'b1;
    w_accel_next   = r_accel;
    if (!enable) begin
      w_timer_load = 1'b1;
      w_accel_next = '0;
    end else if (!pause) begin
      if (w_dir_req == DIR_NONE) begin
        w_timer_load = 1'b1;
        w_accel_next = '0;
      end else if (w_dir_req != r_cur_dir) begin
        // Start from idle or a reversal: immediate step, slow period.
        w_take_step    = 1'b1;
        w_step_dir     = w_dir_req;
        w_accel_next   = ACC_ONE;
        w_timer_load   = 1'b1;
        w_timer_period = RELOAD_SLOW;
      end else if (w_expire) begin
        w_take_step    = 1'b1;
        w_step_dir     = r_cur_dir;
        w_accel_next   = w_accel_inc;
        w_timer_load   = 1'b1;
        w_timer_period = (w_accel_inc >= ACC_MAX) ? RELOAD_FAST : RELOAD_SLOW;
      end
    end
    w_ph_next = phase_advance(r_ph, w_step_dir);
  end

  step_timer #(
    .CNT_W (CNT_W)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .hold   (w_timer_hold),
    .load   (w_timer_load),
    .period (w_timer_period),
    .expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_dir <= DIR_NONE;
      r_ph      <= PH_RESET;
      r_accel   <= '0;
      r_dial    <= DIAL_RESET;
      r_step    <= 1'b0;
      r_moving  <= 1'b0;
    end else if (!enable) begin
      r_cur_dir <= DIR_NONE;
      r_ph      <= PH_RESET;
      r_accel   <= '0;
      r_dial    <= DIAL_RESET;
      r_step    <= 1'b0;
      r_moving  <= 1'b0;
    end else if (pause) begin
      r_step <= 1'b0;
    end else begin
      r_cur_dir <= w_dir_req;
      r_moving  <= (w_dir_req != DIR_NONE);
      r_accel   <= w_accel_next;
      r_step    <= w_take_step;
      if (w_take_step) begin
        r_ph   <= w_ph_next;
        r_dial <= phase_to_dial(w_ph_next);
      end
    end
  end

  assign dial   = r_dial;
  assign step   = r_step;
  assign moving = r_moving;

endmodule
